// File: rtl/sprite_renderer_if.sv
// Object pixel-query, sprite-ROM and frame-buffer write signals of the sprite renderer.
// The renderer is the master of all three; object modules, ROM and frame buffer sit on the slave side.
interface sprite_renderer_if #(
  parameter int ROM_AW  = 13,
  parameter int COLOR_W = 4
);
  logic [8:0]         PixelX;
  logic [8:0]         PixelY;
  logic               is_obj;
  logic [ROM_AW-1:0]  Obj_address;
  logic [ROM_AW-1:0]  rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic [16:0]        fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_we;
  logic               fb_ready;

  modport master (
    output PixelX, PixelY, rom_addr, fb_addr, fb_data, fb_we,
    input  is_obj, Obj_address, rom_data, fb_ready
  );

  modport slave (
    input  PixelX, PixelY, rom_addr, fb_addr, fb_data, fb_we,
    output is_obj, Obj_address, rom_data, fb_ready
  );
endinterface

// File: rtl/sprite_renderer.sv
// Frame-scan compositor: raster-queries object modules, fetches sprite texels, resolves
// transparency and streams one palette index per pixel into the frame buffer.
module sprite_renderer #(
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  parameter int ROM_AW      = 13,
  parameter int COLOR_W     = 4,
  parameter int TRANSPARENT = 0,
  parameter int BG_COLOR    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  sprite_renderer_if.master bus,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [COLOR_W-1:0] TRANSP_C = COLOR_W'(TRANSPARENT);
  localparam logic [COLOR_W-1:0] BG_C     = COLOR_W'(BG_COLOR);
  localparam logic [8:0]         X_LAST   = 9'(H_RES - 1);
  localparam logic [8:0]         Y_LAST   = 9'(V_RES - 1);
  localparam logic [16:0]        H_RES_C  = 17'(H_RES);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic                fc_meta_q, fc_sync_q, fc_dly_q;
  logic                tick, adv;
  logic [8:0]          x_q, x_d, y_q, y_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s1_obj_q, s1_obj_d;
  logic [ROM_AW-1:0]   s1_raddr_q, s1_raddr_d;
  logic [16:0]         s1_fbaddr_q, s1_fbaddr_d;
  logic                fb_we_q, fb_we_d;
  logic [16:0]         fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0]  fb_data_q, fb_data_d;
  logic                overrun_q, overrun_d;

  // The synchroniser keeps sampling through Reset so a frame_clk already high at release
  // is not mistaken for a fresh edge.
  always_ff @(posedge Clk) begin
    fc_meta_q <= frame_clk;
    fc_sync_q <= fc_meta_q;
    fc_dly_q  <= fc_sync_q;
  end

  assign tick = fc_sync_q & ~fc_dly_q;
  assign adv  = !(fb_we_q && !bus.fb_ready);

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latches).
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    s1_valid_d  = s1_valid_q;
    s1_obj_d    = s1_obj_q;
    s1_raddr_d  = s1_raddr_q;
    s1_fbaddr_d = s1_fbaddr_q;
    fb_we_d     = fb_we_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    overrun_d   = overrun_q | (tick && (state_q != IDLE));
    frame_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN: begin
        if (adv) begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = DRAIN;
            x_d     = '0;
            y_d     = '0;
          end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 9'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      DRAIN: begin
        if (!s1_valid_q && (!fb_we_q || bus.fb_ready)) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      s1_valid_d  = (state_q == SCAN);
      s1_obj_d    = bus.is_obj;
      s1_raddr_d  = bus.Obj_address;
      // Y*H_RES+X; with H_RES=320 the constant multiply is (Y<<8)+(Y<<6)+X.
      s1_fbaddr_d = 17'(y_q) * H_RES_C + 17'(x_q);
      fb_we_d     = s1_valid_q;
      fb_addr_d   = s1_fbaddr_q;
      fb_data_d   = (s1_obj_q && bus.rom_data != TRANSP_C) ? bus.rom_data : BG_C;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_obj_q    <= 1'b0;
      s1_raddr_q  <= '0;
      s1_fbaddr_q <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      s1_valid_q  <= s1_valid_d;
      s1_obj_q    <= s1_obj_d;
      s1_raddr_q  <= s1_raddr_d;
      s1_fbaddr_q <= s1_fbaddr_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      overrun_q   <= overrun_d;
    end
  end

  // During a stall the ROM re-reads the stage-1 address so rom_data keeps matching stage 1.
  assign bus.rom_addr = adv ? bus.Obj_address : s1_raddr_q;
  assign bus.PixelX   = x_q;
  assign bus.PixelY   = y_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer on a reduced 24x16 raster so several whole frames fit
// in the cycle budget; object window, stall point and overrun/reset points are scaled to match.
module tb_sprite_renderer;

  localparam int H  = 24;
  localparam int V  = 16;
  localparam int N  = H * V;
  localparam int BG = 1;

  logic Clk, Reset, frame_clk;
  logic busy, frame_done, overrun;

  sprite_renderer_if #(.ROM_AW(13), .COLOR_W(4)) bus ();

  sprite_renderer #(.H_RES(H), .V_RES(V)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .bus        (bus.master),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  // obj_mode: 0 no objects, 1 window X 5..12 / Y 3..7 with address DistX+DistY*8,
  // 2 everywhere with address X+Y*H.  rom_mode: 0 returns addr[3:0], 1 returns 0.
  int obj_mode;
  int rom_mode;
  int stall_mode;
  int frame_id;

  always_comb begin
    bus.is_obj      = 1'b0;
    bus.Obj_address = '0;
    if (obj_mode == 1 && bus.PixelX >= 9'd5 && bus.PixelX <= 9'd12 &&
        bus.PixelY >= 9'd3 && bus.PixelY <= 9'd7) begin
      bus.is_obj      = 1'b1;
      bus.Obj_address = 13'(bus.PixelX - 9'd5) + 13'(bus.PixelY - 9'd3) * 13'd8;
    end else if (obj_mode == 2) begin
      bus.is_obj      = 1'b1;
      bus.Obj_address = 13'(bus.PixelX) + 13'(bus.PixelY) * 13'(H);
    end
  end

  always @(posedge Clk)
    bus.rom_data <= (rom_mode == 0) ? bus.rom_addr[3:0] : 4'd0;

  logic [16:0] wr_addr_q[$];
  logic [3:0]  wr_data_q[$];

  // fb_ready driver: 5-cycle stall once 100 pixels are written, then 50% random.
  initial begin
    int seen_id = 0;
    int burst_cnt = 0;
    bit burst_done = 0;
    bus.fb_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #2;
      if (frame_id != seen_id) begin
        seen_id    = frame_id;
        burst_cnt  = 0;
        burst_done = 0;
      end
      if (stall_mode == 0) bus.fb_ready = 1'b1;
      else if (!burst_done && wr_addr_q.size() >= 100) begin
        bus.fb_ready = 1'b0;
        burst_cnt++;
        if (burst_cnt >= 5) burst_done = 1;
      end else if (burst_done) bus.fb_ready = 1'($urandom_range(0, 1));
      else bus.fb_ready = 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;
  int busy_cycles, done_pulses, done_k, first_we_k, stall_cycles;

  function automatic logic [3:0] exp_data(input int i);
    int x = i % H;
    int y = i / H;
    int addr;
    logic [3:0] rom;
    if (obj_mode == 0) return 4'(BG);
    if (obj_mode == 1) begin
      if (!(x >= 5 && x <= 12 && y >= 3 && y <= 7)) return 4'(BG);
      addr = (x - 5) + (y - 3) * 8;
    end else addr = x + y * H;
    rom = (rom_mode == 0) ? 4'(addr) : 4'd0;
    return (rom == 4'd0) ? 4'(BG) : rom;
  endfunction

  function automatic int frame_mismatches(output string info);
    int bad = 0;
    info = "none";
    foreach (wr_addr_q[i]) begin
      if (wr_addr_q[i] !== 17'(i) || wr_data_q[i] !== exp_data(i)) begin
        if (bad == 0)
          info = $sformatf("write %0d got addr %0d data %0d, want addr %0d data %0d",
                           i, wr_addr_q[i], wr_data_q[i], i, exp_data(i));
        bad++;
      end
    end
    return bad;
  endfunction

  // Ticks one frame and watches it to completion. retick_at>0 pulses frame_clk again that
  // many cycles after SCAN entry; reset_at>0 asserts Reset once that many writes are seen.
  task automatic run_frame(input int stall_i, input int retick_at, input int reset_at);
    int k = 0;
    bit stalled, stalled_prev = 0;
    logic [16:0] prev_addr = '0;
    logic [3:0]  prev_data = '0;
    logic [12:0] exp_raddr = '0;
    wr_addr_q.delete();
    wr_data_q.delete();
    busy_cycles = 0; done_pulses = 0; done_k = -1; first_we_k = -1; stall_cycles = 0;
    stall_mode = stall_i;
    frame_id++;
    @(posedge Clk);
    #2 frame_clk = 1'b1;
    @(negedge Clk);
    while (!busy && k < 10) begin
      @(negedge Clk);
      k++;
    end
    if (!busy) begin
      checks++; errors++;
      $display("FAIL tick_start busy=%0d after %0d cycles, required 1", busy, k);
      frame_clk = 1'b0;
      return;
    end
    k = 0;
    while (k < 30 * N) begin
      if (!busy) break;
      busy_cycles++;
      if (frame_done) begin done_pulses++; done_k = k; end
      if (bus.fb_we && first_we_k < 0) first_we_k = k;
      if (stalled_prev) begin
        checks++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== prev_addr || bus.fb_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold cycle %0d got we=%0d addr=%0d data=%0d, required 1/%0d/%0d",
                   k, bus.fb_we, bus.fb_addr, bus.fb_data, prev_addr, prev_data);
        end
      end
      stalled = bus.fb_we && !bus.fb_ready;
      if (stalled) begin
        stall_cycles++;
        checks++;
        if (bus.rom_addr !== exp_raddr) begin
          errors++;
          $display("FAIL stall_rom_addr cycle %0d got %0d, required %0d", k, bus.rom_addr, exp_raddr);
        end
      end else exp_raddr = bus.Obj_address;
      if (bus.fb_we && bus.fb_ready) begin
        wr_addr_q.push_back(bus.fb_addr);
        wr_data_q.push_back(bus.fb_data);
      end
      stalled_prev = stalled;
      prev_addr = bus.fb_addr;
      prev_data = bus.fb_data;
      if (k == 0) frame_clk = 1'b0;
      if (retick_at > 0 && k == retick_at) frame_clk = 1'b1;
      if (retick_at > 0 && k == retick_at + 5) frame_clk = 1'b0;
      if (reset_at > 0 && wr_addr_q.size() >= reset_at) begin
        Reset = 1'b1;
        return;
      end
      @(negedge Clk);
      k++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL frame_timeout busy still %0d after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic check_frame(input string name, input bit stall_free);
    string info;
    int bad;
    checks++;
    if (wr_addr_q.size() !== N) begin
      errors++;
      $display("FAIL %s_write_count got %0d, required %0d", name, wr_addr_q.size(), N);
    end
    checks++;
    bad = frame_mismatches(info);
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_contents got %0d bad writes, required 0 (%s)", name, bad, info);
    end
    checks++;
    if (done_pulses !== 1) begin
      errors++;
      $display("FAIL %s_frame_done got %0d pulses, required 1", name, done_pulses);
    end
    checks++;
    if (busy_cycles !== N + 2 + stall_cycles) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d, required %0d", name, busy_cycles, N + 2 + stall_cycles);
    end
    if (stall_free) begin
      checks++;
      if (done_k !== N + 1) begin
        errors++;
        $display("FAIL %s_done_cycle got %0d, required %0d", name, done_k, N + 1);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks += 8;
    if (bus.PixelX !== 9'd0)  begin errors++; $display("FAIL reset_PixelX got %0d, required 0", bus.PixelX); end
    if (bus.PixelY !== 9'd0)  begin errors++; $display("FAIL reset_PixelY got %0d, required 0", bus.PixelY); end
    if (bus.fb_we !== 1'b0)   begin errors++; $display("FAIL reset_fb_we got %0d, required 0", bus.fb_we); end
    if (bus.fb_addr !== 17'd0) begin errors++; $display("FAIL reset_fb_addr got %0d, required 0", bus.fb_addr); end
    if (bus.fb_data !== 4'd0) begin errors++; $display("FAIL reset_fb_data got %0d, required 0", bus.fb_data); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0d, required 0", busy); end
    if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_frame_done got %0d, required 0", frame_done); end
    if (overrun !== 1'b0)     begin errors++; $display("FAIL reset_overrun got %0d, required 0", overrun); end
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_tick busy got %0d, required 0", busy); end
  endtask

  task automatic test_no_objects();
    obj_mode = 0; rom_mode = 0;
    run_frame(0, 0, 0);
    check_frame("no_objects", 1);
    checks += 2;
    if (first_we_k !== 2) begin errors++; $display("FAIL latency got %0d, required 2", first_we_k); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL no_objects_overrun got %0d, required 0", overrun); end
  endtask

  task automatic test_object_window();
    int idx[5]     = '{77, 78, 79, 180, 181};
    logic [3:0] ex[5] = '{4'd1, 4'd1, 4'd2, 4'd7, 4'd1};
    obj_mode = 1; rom_mode = 0;
    run_frame(0, 0, 0);
    check_frame("object_window", 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_data_q.size() <= idx[i] || wr_data_q[idx[i]] !== ex[i]) begin
        errors++;
        $display("FAIL window_pixel_%0d got %0d, required %0d", idx[i],
                 (wr_data_q.size() > idx[i]) ? wr_data_q[idx[i]] : 4'hx, ex[i]);
      end
    end
  endtask

  task automatic test_transparency();
    obj_mode = 2; rom_mode = 1;
    run_frame(0, 0, 0);
    check_frame("transparency", 1);
  endtask

  task automatic test_backpressure();
    obj_mode = 2; rom_mode = 0;
    run_frame(1, 0, 0);
    check_frame("backpressure", 0);
    checks++;
    if (stall_cycles < 5) begin
      errors++;
      $display("FAIL backpressure_stalls got %0d stall cycles, required at least 5", stall_cycles);
    end
  endtask

  task automatic test_overrun();
    obj_mode = 0; rom_mode = 0;
    run_frame(0, 100, 0);
    check_frame("overrun", 1);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %0d, required 1", overrun); end
    repeat (20) @(negedge Clk);
    checks += 3;
    if (busy !== 1'b0)    begin errors++; $display("FAIL overrun_no_restart busy got %0d, required 0", busy); end
    if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL overrun_no_writes fb_we got %0d, required 0", bus.fb_we); end
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0d, required 1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int late_writes = 0;
    obj_mode = 1; rom_mode = 0;
    run_frame(0, 0, 200);
    @(negedge Clk);
    checks += 5;
    if (bus.fb_we !== 1'b0)  begin errors++; $display("FAIL midreset_fb_we got %0d, required 0", bus.fb_we); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL midreset_busy got %0d, required 0", busy); end
    if (bus.PixelX !== 9'd0) begin errors++; $display("FAIL midreset_PixelX got %0d, required 0", bus.PixelX); end
    if (bus.PixelY !== 9'd0) begin errors++; $display("FAIL midreset_PixelY got %0d, required 0", bus.PixelY); end
    if (overrun !== 1'b0)    begin errors++; $display("FAIL midreset_overrun got %0d, required 0", overrun); end
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (bus.fb_we) late_writes++;
    end
    checks++;
    if (late_writes !== 0) begin errors++; $display("FAIL midreset_aborted got %0d writes, required 0", late_writes); end
    run_frame(0, 0, 0);
    check_frame("after_reset", 1);
  endtask

  initial begin
    obj_mode = 0; rom_mode = 0; stall_mode = 0; frame_id = 0;
    Reset = 1'b1;
    frame_clk = 1'b0;
    test_reset();
    test_no_objects();
    test_object_window();
    test_transparency();
    test_backpressure();
    test_overrun();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
